ahb3lite_sram1rw: RTL and testbench



---
 rtl/ahb3lite_sram1rw.sv | 95 +++++++++
 tb/tb_ahb3lite_sram1rw.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_sram1rw.sv
// Zero-wait-state AHB3-Lite slave backed by a single-port word-organised SRAM.
// Writes commit at the end of their data phase; reads are served combinationally.
module ahb3lite_sram1rw #(
  parameter int unsigned MEM_SIZE   = 64,
  parameter int unsigned HADDR_SIZE = 16,
  parameter int unsigned HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [HDATA_SIZE-1:0] HRDATA
);

  localparam int unsigned AddrW = $clog2(MEM_SIZE);
  localparam int unsigned Words = MEM_SIZE / 4;
  localparam int unsigned IdxW  = (AddrW > 2) ? AddrW - 2 : 1;

  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  logic [31:0] mem [Words];

  logic             accept;
  logic             commit;
  logic             dp_valid_q;
  logic             dp_write_q;
  logic [2:0]       dp_size_q;
  logic [AddrW-1:0] dp_addr_q;
  logic [IdxW-1:0]  word_idx;
  logic [3:0]       byte_en;

  // Burst type, protection and upper address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HADDR};

  assign accept = HSEL && HREADY && ((HTRANS == TransNonseq) || (HTRANS == TransSeq));
  assign commit = HRESETn && HREADY && dp_valid_q && dp_write_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_size_q  <= 3'd0;
      dp_addr_q  <= '0;
    end else if (HREADY) begin
      dp_valid_q <= accept;
      if (accept) begin
        dp_write_q <= HWRITE;
        dp_size_q  <= HSIZE;
        dp_addr_q  <= HADDR[AddrW-1:0];
      end
    end
  end

  if (AddrW > 2) begin : gen_idx
    assign word_idx = dp_addr_q[AddrW-1:2];
  end else begin : gen_idx_single
    assign word_idx = '0;
  end

  always_comb begin
    byte_en = 4'b1111;
    case (dp_size_q)
      3'd0:    byte_en = 4'b0001 << dp_addr_q[1:0];
      3'd1:    byte_en = dp_addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Memory has no reset; contents survive HRESETn.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign HRDATA    = (dp_valid_q && !dp_write_q) ? mem[word_idx] : '0;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb3lite_sram1rw.sv
// Directed plus randomized bench for ahb3lite_sram1rw against a byte-array reference model.
module tb_ahb3lite_sram1rw;

  localparam int unsigned MEM = 64;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] NSEQ = 2'b10;
  localparam logic [1:0] SEQT = 2'b11;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [15:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  ahb3lite_sram1rw #(
    .MEM_SIZE  (MEM),
    .HADDR_SIZE(16),
    .HDATA_SIZE(32)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HBURST   (HBURST),
    .HPROT    (HPROT),
    .HTRANS   (HTRANS),
    .HREADY   (HREADY),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .HRDATA   (HRDATA)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int checks = 0;
  int errors = 0;

  // Reference: byte-addressed memory with a written flag per byte.
  logic [7:0] mdl [MEM];
  bit         known [MEM];

  // Outstanding data phase as seen by the bus.
  bit          pend_v;
  bit          pend_w;
  logic [15:0] pend_a;
  logic [2:0]  pend_s;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model_write(input logic [15:0] a, input logic [2:0] s,
                                      input logic [31:0] d);
    int unsigned n;
    int unsigned base;
    int unsigned b;
    n = (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
    base = (int'(a) % MEM) & ~(n - 1);
    for (int i = 0; i < int'(n); i++) begin
      b = base + i;
      mdl[b]   = d[8*(b%4) +: 8];
      known[b] = 1'b1;
    end
  endfunction

  function automatic bit model_known(input logic [15:0] a);
    int unsigned base;
    base = (int'(a) % MEM) & ~3;
    return known[base] && known[base+1] && known[base+2] && known[base+3];
  endfunction

  function automatic logic [31:0] model_word(input logic [15:0] a);
    int unsigned base;
    base = (int'(a) % MEM) & ~3;
    return {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
  endfunction

  // One bus cycle: drive, check outputs mid-cycle, advance the model at the edge.
  task automatic step(input bit rst, input bit sel, input logic [1:0] trans, input bit wr,
                      input logic [15:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input bit rdy);
    HRESETn = rst;
    HSEL    = sel;
    HTRANS  = trans;
    HWRITE  = wr;
    HADDR   = addr;
    HSIZE   = size;
    HWDATA  = wdata;
    HREADY  = rdy;
    HBURST  = 3'($urandom);
    HPROT   = 4'($urandom);
    @(negedge HCLK);
    last_rd = HRDATA;
    check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("hresp", {31'd0, HRESP}, 32'd0);
    if (pend_v && !pend_w) begin
      if (model_known(pend_a)) check("hrdata_read", HRDATA, model_word(pend_a));
    end else begin
      check("hrdata_idle", HRDATA, 32'd0);
    end
    @(posedge HCLK);
    if (!rst) begin
      pend_v = 1'b0;
    end else if (rdy) begin
      if (pend_v && pend_w) model_write(pend_a, pend_s, wdata);
      pend_v = sel && trans[1];
      pend_w = wr;
      pend_a = addr;
      pend_s = size;
    end
    #1;
  endtask

  task automatic wr_single(input logic [15:0] addr, input logic [2:0] size,
                           input logic [31:0] data);
    step(1, 1, NSEQ, 1, addr, size, $urandom, 1);
    step(1, 0, IDLE, 0, 16'd0, 3'd0, data, 1);
  endtask

  task automatic rd_single(input logic [15:0] addr);
    step(1, 1, NSEQ, 0, addr, 3'd2, $urandom, 1);
    step(1, 0, IDLE, 0, 16'd0, 3'd0, $urandom, 1);
  endtask

  initial begin
    for (int i = 0; i < int'(MEM); i++) begin
      mdl[i]   = 8'h00;
      known[i] = 1'b0;
    end
    pend_v  = 1'b0;
    pend_w  = 1'b0;
    pend_a  = '0;
    pend_s  = '0;
    last_rd = '0;
    HRESETn = 1'b0;
    HSEL    = 1'b0;
    HTRANS  = IDLE;
    HWRITE  = 1'b0;
    HADDR   = '0;
    HSIZE   = 3'd0;
    HWDATA  = '0;
    HREADY  = 1'b1;
    HBURST  = '0;
    HPROT   = '0;
    @(posedge HCLK);
    #1;

    // Reset state.
    step(0, 0, IDLE, 0, 16'd0, 3'd0, 32'd0, 1);
    step(1, 0, IDLE, 0, 16'd0, 3'd0, 32'd0, 1);
    check("reset_hrdata", last_rd, 32'd0);

    // Word write then read.
    wr_single(16'd4, 3'd2, 32'hDEADBEEF);
    rd_single(16'd4);
    check("word_rw", last_rd, 32'hDEADBEEF);

    // Byte and halfword merges.
    wr_single(16'd8, 3'd2, 32'h11223344);
    wr_single(16'd9, 3'd0, 32'h0000AA00);
    wr_single(16'd10, 3'd1, 32'hBBCC0000);
    rd_single(16'd8);
    check("byte_half_merge", last_rd, 32'hBBCCAA44);

    // Unselected, IDLE and BUSY writes must not touch memory.
    step(1, 0, NSEQ, 1, 16'd4, 3'd2, $urandom, 1);
    step(1, 1, IDLE, 1, 16'd4, 3'd2, 32'h12345678, 1);
    step(1, 1, BUSY, 1, 16'd4, 3'd2, 32'h12345678, 1);
    step(1, 0, IDLE, 0, 16'd0, 3'd0, 32'h12345678, 1);
    rd_single(16'd4);
    check("no_xfer_write", last_rd, 32'hDEADBEEF);

    // HREADY low throughout: nothing is accepted.
    wr_single(16'd12, 3'd2, 32'h0BADC0DE);
    for (int i = 0; i < 4; i++) step(1, 1, NSEQ, 1, 16'd12, 3'd2, 32'hCAFEF00D, 0);
    step(1, 0, IDLE, 0, 16'd0, 3'd0, 32'hCAFEF00D, 1);
    rd_single(16'd12);
    check("hready_low_write", last_rd, 32'h0BADC0DE);

    // Data-phase stall, then pipelined read of the same word.
    wr_single(16'd16, 3'd2, 32'h01020304);
    step(1, 1, NSEQ, 1, 16'd16, 3'd2, $urandom, 1);
    step(1, 1, NSEQ, 0, 16'd16, 3'd2, 32'h55AA55AA, 0);
    step(1, 1, NSEQ, 0, 16'd16, 3'd2, 32'h55AA55AA, 0);
    step(1, 1, NSEQ, 0, 16'd16, 3'd2, 32'h55AA55AA, 1);
    step(1, 0, IDLE, 0, 16'd0, 3'd0, $urandom, 1);
    check("stall_raw", last_rd, 32'h55AA55AA);

    // Back-to-back pipelined transfers, one per cycle.
    step(1, 1, NSEQ, 1, 16'd20, 3'd2, $urandom, 1);
    step(1, 1, SEQT, 1, 16'd24, 3'd2, 32'h0A0B0C0D, 1);
    step(1, 1, NSEQ, 0, 16'd20, 3'd2, 32'hF0E0D0C0, 1);
    step(1, 1, SEQT, 0, 16'd24, 3'd2, $urandom, 1);
    check("pipe_rd20", last_rd, 32'h0A0B0C0D);
    step(1, 0, IDLE, 0, 16'd0, 3'd0, $urandom, 1);
    check("pipe_rd24", last_rd, 32'hF0E0D0C0);

    // Aliasing modulo MEM_SIZE.
    wr_single(16'h0044, 3'd2, 32'hA5A51234);
    rd_single(16'h0004);
    check("alias", last_rd, 32'hA5A51234);

    // Reset in a write data phase discards the write; transfers during reset are ignored.
    step(1, 1, NSEQ, 1, 16'd4, 3'd2, $urandom, 1);
    step(0, 1, NSEQ, 1, 16'd4, 3'd2, 32'h77777777, 1);
    step(0, 1, NSEQ, 1, 16'd4, 3'd2, 32'h77777777, 1);
    check("reset_hrdata_mid", last_rd, 32'd0);
    step(1, 0, IDLE, 0, 16'd0, 3'd0, 32'h77777777, 1);
    check("after_reset_hrdata", last_rd, 32'd0);
    rd_single(16'd4);
    check("reset_discard", last_rd, 32'hA5A51234);

    // Randomized pipelined traffic with stalls and occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 60) != 0, ($urandom % 4) != 0, 2'($urandom), 1'($urandom),
           16'($urandom), 3'($urandom), $urandom, ($urandom % 4) != 0);
    end

    // Sweep back every word through the model.
    for (int a = 0; a < int'(MEM); a += 4) rd_single(16'(a));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
